// File: rtl/axi_cmd_master.sv
// axi_cmd_master: single-outstanding bridge from a cmd/rsp handshake to single-beat AXI
// write (AW+W->B) and read (AR->R) transactions, with an optional per-phase timeout.
module axi_cmd_master #(
  parameter logic [3:0] AXI_ID = 4'h0,
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        areset,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  input  logic [3:0]  cmd_wstrb_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic [1:0]  rsp_resp_o,
  output logic [3:0]  awid_o,
  output logic [31:0] awaddr_o,
  output logic        awvalid_o,
  input  logic        awready_i,
  output logic [3:0]  wid_o,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic        wlast_o,
  output logic        wvalid_o,
  input  logic        wready_i,
  output logic [3:0]  arid_o,
  output logic [31:0] araddr_o,
  output logic        arvalid_o,
  input  logic        arready_i,
  input  logic [3:0]  rid_i,
  input  logic [31:0] rdata_i,
  input  logic        rlast_i,
  input  logic        rvalid_i,
  output logic        rready_o,
  input  logic [3:0]  bid_i,
  input  logic [1:0]  bresp_i,
  input  logic        bvalid_i,
  output logic        bready_o
);
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;
  state_t state, state_nx;
  logic aw_done, w_done, aw_hs, w_hs, wr_req_done, expire;
  logic [15:0] cnt;
  logic [31:0] addr, rdata_nx;
  logic [1:0] resp_nx;
  logic unused_rlast;
  assign unused_rlast = rlast_i;
  assign awid_o = AXI_ID;
  assign wid_o = AXI_ID;
  assign arid_o = AXI_ID;
  assign awaddr_o = addr;
  assign araddr_o = addr;
  assign cmd_ready_o = state == IDLE;
  assign awvalid_o = state == WR_REQ && !aw_done;
  assign wvalid_o = state == WR_REQ && !w_done;
  assign wlast_o = wvalid_o;
  assign bready_o = state == WR_RESP;
  assign arvalid_o = state == RD_REQ;
  assign rready_o = state == RD_DATA;
  assign rsp_valid_o = state == RSP;
  assign aw_hs = awvalid_o & awready_i;
  assign w_hs = wvalid_o & wready_i;
  assign wr_req_done = (aw_done | aw_hs) & (w_done | w_hs);
  // completion on the final allowed cycle wins over the abort
  assign expire = TIMEOUT != 0 && cnt == 16'(TIMEOUT - 1);
  always_comb begin
    state_nx = state;
    resp_nx = rsp_resp_o;
    rdata_nx = rsp_rdata_o;
    case (state)
      IDLE:    state_nx = cmd_valid_i ? (cmd_we_i ? WR_REQ : RD_REQ) : IDLE;
      WR_REQ:  state_nx = wr_req_done ? WR_RESP : (expire ? RSP : WR_REQ);
      WR_RESP: state_nx = bvalid_i || expire ? RSP : WR_RESP;
      RD_REQ:  state_nx = arready_i ? RD_DATA : (expire ? RSP : RD_REQ);
      RD_DATA: state_nx = rvalid_i || expire ? RSP : RD_DATA;
      RSP:     state_nx = rsp_ready_i ? IDLE : RSP;
      default: state_nx = IDLE;
    endcase
    if (state == WR_RESP && bvalid_i) begin
      resp_nx = bid_i == AXI_ID ? bresp_i : 2'b10;
      rdata_nx = '0;
    end else if (state == RD_DATA && rvalid_i) begin
      resp_nx = rid_i == AXI_ID ? 2'b00 : 2'b10;
      rdata_nx = rdata_i;
    end else if (state != IDLE && state != RSP && state_nx == RSP) begin
      resp_nx = 2'b11;
      rdata_nx = '0;
    end
  end
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state <= IDLE;
      cnt <= '0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      addr <= '0;
      wdata_o <= '0;
      wstrb_o <= '0;
      rsp_rdata_o <= '0;
      rsp_resp_o <= 2'b00;
    end else begin
      state <= state_nx;
      cnt <= state_nx != state ? 16'd0 : cnt + 16'd1;
      aw_done <= state_nx == WR_REQ && (aw_done | aw_hs);
      w_done <= state_nx == WR_REQ && (w_done | w_hs);
      rsp_rdata_o <= rdata_nx;
      rsp_resp_o <= resp_nx;
      if (state == IDLE && cmd_valid_i) begin
        addr <= cmd_addr_i;
        wdata_o <= cmd_wdata_i;
        wstrb_o <= cmd_wstrb_i;
      end
    end
  end
endmodule

// File: doc/axi_cmd_master.md
# axi_cmd_master

Single-outstanding AXI master that converts a simple command/response handshake into single-beat AXI write (AW+W→B) and read (AR→R) transactions. Sits directly upstream of the counter register slave and drives its AW/W/AR channels while consuming its B/R channels. Host-side logic (test sequencer, control FSM) issues one register access at a time and receives read data or an error code back. Includes an optional per-transaction timeout so a hung slave cannot lock the command path.

## Interface
- AXI_ID, 4'h0, ID driven on awid_o/wid_o/arid_o and expected back on bid_i/rid_i
- TIMEOUT, 256, cycles waited in any AXI-wait state before abort; 0 disables timeout
- clk  in  1  clock; all logic on rising edge
- areset  in  1  asynchronous, active-low reset
- cmd_valid_i / cmd_ready_o  in/out  1  command handshake
- cmd_we_i  in  1  1 = write, 0 = read
- cmd_addr_i  in  32  register address, passed unchanged to awaddr_o/araddr_o
- cmd_wdata_i  in  32  write data;  cmd_wstrb_i  in  4  byte strobes
- rsp_valid_o / rsp_ready_i  out/in  1  response handshake
- rsp_rdata_o  out  32  read data (0 for writes)
- rsp_resp_o  out  2  00 OKAY, 10 ID mismatch, 11 timeout; write returns bresp_i when ID matches
- awid_o 4, awaddr_o 32, awvalid_o 1 (out); awready_i 1 (in)
- wid_o 4, wdata_o 32, wstrb_o 4, wlast_o 1, wvalid_o 1 (out); wready_i 1 (in)
- arid_o 4, araddr_o 32, arvalid_o 1 (out); arready_i 1 (in)
- rid_i 4, rdata_i 32, rlast_i 1, rvalid_i 1 (in); rready_o 1 (out)
- bid_i 4, bresp_i 2, bvalid_i 1 (in); bready_o 1 (out)

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE: cmd_ready_o = 1 (only state where it is 1). On cmd_valid_i&cmd_ready_o capture we/addr/wdata/wstrb into registers; go WR_REQ (we=1) or RD_REQ (we=0).
- WR_REQ: awvalid_o and wvalid_o asserted together; each drops independently the cycle after its own handshake (awvalid&awready, wvalid&wready). Both done (same or different cycles) → WR_RESP. wlast_o = wvalid_o.
- WR_RESP: bready_o = 1. On bvalid_i: rsp_resp = (bid_i==AXI_ID) ? bresp_i : 2'b10; rsp_rdata = 0; → RSP.
- RD_REQ: arvalid_o = 1 until arvalid&arready → RD_DATA.
- RD_DATA: rready_o = 1. On rvalid_i: rsp_rdata = rdata_i; rsp_resp = (rid_i==AXI_ID) ? 2'b00 : 2'b10; → RSP. rlast_i ignored (single beat).
- RSP: rsp_valid_o = 1 until rsp_valid_o&rsp_ready_i → IDLE.
- Timeout: 16-bit counter cleared on entry to WR_REQ/WR_RESP/RD_REQ/RD_DATA, increments each cycle there; at count == TIMEOUT-1 without completing, drop all AXI valids/readies, rsp_resp = 2'b11, rsp_rdata = 0, → RSP. Deliberate protocol abort; late B/R beats arriving in IDLE/RSP are ignored (bready_o/rready_o = 0).
- Outputs awaddr/araddr/wdata/wstrb held stable from capture until next command accept.

## Timing
- Reset (areset low): state IDLE; cmd_ready_o 1; all *valid_o, bready_o, rready_o 0; rsp_rdata_o 0; rsp_resp_o 00; awaddr_o/araddr_o/wdata_o 0; wstrb_o 0; IDs = AXI_ID.
- Reset mid-transaction: immediate return to reset values; in-flight command lost, no response.
- All AXI/response outputs are registered or decoded from registered state; no combinational path cmd_* → AXI outputs or AXI inputs → AXI outputs.
- Zero-wait slave, write: accept edge 0; AW/W handshake edge 1; bvalid seen edge 2; rsp_valid_o high cycle 3. Read: accept edge 0; AR edge 1; R edge 2; rsp_valid_o cycle 3.
- Back-to-back: next cmd_ready_o high the cycle after rsp handshake; minimum 4 cycles per command.
- One outstanding transaction; never issues AR while a write is pending or vice versa.

## Test plan
- Write addr 3, data 32'hDEADBEEF, strb 4'hF, slave always ready, bresp 00 → AW/W handshake same cycle, rsp_resp 00, rsp_valid at cycle 3.
- Read addr 3 after above, slave returns rdata 32'hDEADBEEF, rid 0 → rsp_rdata 32'hDEADBEEF, rsp_resp 00.
- Write with awready held low 5 cycles, wready immediate → wvalid drops after cycle 1, awvalid holds until handshake, single bready phase, rsp OK.
- Read with rid_i = 4'h5 (AXI_ID 0) → rsp_resp 2'b10, data still returned.
- TIMEOUT=8, slave never asserts bvalid → at 8th WR_RESP cycle bready drops, rsp_resp 2'b11; rsp_ready held low 3 cycles → rsp_valid stays high, then IDLE.
- areset pulsed low during RD_DATA → all outputs to reset values, cmd_ready_o 1, no rsp_valid.
